// File: rtl/crc8_pkg.sv
// CRC8 arbiter shared definitions: polynomial, seed and FSM state encoding.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h9B;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC
    } state_t;

endpackage : crc8_pkg

// File: rtl/crc8_arb_ctrl_if.sv
// Byte-stream bus for crc8_arb_ctrl: two requester streams in, one merged stream out.
// The slave modport is the controller's view; master is the environment's view.
interface crc8_arb_ctrl_if;

    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;

    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;

    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       m_src;

    modport slave (
        input  s0_valid, s0_data, s0_last,
        input  s1_valid, s1_data, s1_last,
        input  m_ready,
        output s0_ready, s1_ready,
        output m_valid, m_data, m_last, m_src
    );

    modport master (
        output s0_valid, s0_data, s0_last,
        output s1_valid, s1_data, s1_last,
        output m_ready,
        input  s0_ready, s1_ready,
        input  m_valid, m_data, m_last, m_src
    );

endinterface : crc8_arb_ctrl_if

// File: rtl/crc8_next.sv
// One-byte CRC8 step: MSB-first, no reflection, polynomial from crc8_pkg.
module crc8_next
    import crc8_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] byte_i,
    output logic [7:0] crc_o
);

    // Shift the byte through the LFSR eight times.
    always_comb begin
        // NOTE: blocking assignments here so each iteration builds on the previous one.
        crc_o = crc_i ^ byte_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_o[7]) crc_o = {crc_o[6:0], 1'b0} ^ CRC8_POLY;
            else          crc_o = {crc_o[6:0], 1'b0};
        end
    end

endmodule : crc8_next

// File: rtl/crc8_arb_ctrl.sv
// Two-requester round-robin frame arbiter that appends a CRC8 byte to each frame.
// Optional DATA-state timeout is enabled by defining CRC8_TIMEOUT_EN.
module crc8_arb_ctrl
    import crc8_pkg::*;
`ifdef CRC8_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    crc8_arb_ctrl_if.slave   bus,
    output logic             busy
`ifdef CRC8_TIMEOUT_EN
    ,
    output logic             abort
`endif
);

    state_t     state_q;
    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic       prio_q;
    logic       grant_q;
    logic       grant_d;

    logic       gnt_valid;
    logic       gnt_last;
    logic [7:0] gnt_data;
    logic       data_hs;

`ifdef CRC8_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             abort_q;
    logic             aborted_q;
`endif

    // Granted requester stream and the DATA-state handshake.
    assign gnt_valid = grant_q ? bus.s1_valid : bus.s0_valid;
    assign gnt_last  = grant_q ? bus.s1_last  : bus.s0_last;
    assign gnt_data  = grant_q ? bus.s1_data  : bus.s0_data;
    assign data_hs   = (state_q == DATA) && gnt_valid && bus.m_ready;

    // A tie goes to the priority holder; a sole requester always wins.
    assign grant_d = (bus.s0_valid && bus.s1_valid) ? prio_q : ~bus.s0_valid;

    assign busy = (state_q != IDLE);

    crc8_next u_next (
        .crc_i  (acc_q),
        .byte_i (gnt_data),
        .crc_o  (acc_d)
    );

    // Arbitration FSM, CRC accumulator and optional timeout.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking for all state; acc_q is an ordinary register and is reset with the rest.
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= CRC8_INIT;
            prio_q    <= 1'b0;
            grant_q   <= 1'b0;
`ifdef CRC8_TIMEOUT_EN
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
`ifdef CRC8_TIMEOUT_EN
            abort_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (bus.s0_valid || bus.s1_valid) begin
                        grant_q <= grant_d;
                        acc_q   <= CRC8_INIT;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (data_hs) begin
                        acc_q <= acc_d;
`ifdef CRC8_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        if (gnt_last) state_q <= CRC;
                    end
`ifdef CRC8_TIMEOUT_EN
                    else if (!gnt_valid) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th in a row.
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            cnt_q     <= '0;
                            abort_q   <= 1'b1;
                            aborted_q <= 1'b1;
                            state_q   <= CRC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`endif
                end
                CRC: begin
                    if (bus.m_ready) begin
                        state_q <= IDLE;
                        prio_q  <= ~grant_q;
`ifdef CRC8_TIMEOUT_EN
                        aborted_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output stream steering from the registered state and grant.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        bus.m_valid  = 1'b0;
        bus.m_data   = 8'h00;
        bus.m_last   = 1'b0;
        bus.m_src    = 1'b0;
        bus.s0_ready = 1'b0;
        bus.s1_ready = 1'b0;
        unique case (state_q)
            DATA: begin
                bus.m_valid = gnt_valid;
                bus.m_data  = gnt_data;
                bus.m_src   = grant_q;
                if (grant_q) bus.s1_ready = bus.m_ready;
                else         bus.s0_ready = bus.m_ready;
            end
            CRC: begin
                bus.m_valid = 1'b1;
                bus.m_last  = 1'b1;
                bus.m_src   = grant_q;
`ifdef CRC8_TIMEOUT_EN
                bus.m_data  = aborted_q ? ~acc_q : acc_q;
`else
                bus.m_data  = acc_q;
`endif
            end
            default: ;
        endcase
    end

`ifdef CRC8_TIMEOUT_EN
    assign abort = abort_q;
`endif

endmodule : crc8_arb_ctrl

// File: tb/tb_crc8_arb_ctrl.sv
// Scoreboard bench for crc8_arb_ctrl: drivers push expected bytes, a monitor pops them
// on every output handshake. Define CRC8_TIMEOUT_EN to add the timeout scenario.
module tb_crc8_arb_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       src;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
`ifdef CRC8_TIMEOUT_EN
    logic abort;
    int   abort_cnt;
`endif

    crc8_arb_ctrl_if bus ();

`ifdef CRC8_TIMEOUT_EN
    crc8_arb_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .abort (abort)
    );
`else
    crc8_arb_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   toggle_ready = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic s);
        exp_t e;
        e.data = d;
        e.last = l;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    // Present one byte on requester src and hold it until accepted.
    task automatic send_byte(input logic src, input logic [7:0] d, input logic l);
        int n = 0;
        if (src) begin
            bus.s1_valid = 1'b1; bus.s1_data = d; bus.s1_last = l;
        end else begin
            bus.s0_valid = 1'b1; bus.s0_data = d; bus.s0_last = l;
        end
        forever begin
            @(negedge clk);
            if (src ? bus.s1_ready : bus.s0_ready) break;
            n++;
            if (n > 300) begin
                check(src ? "s1_accept_timeout" : "s0_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (src) bus.s1_valid = 1'b0;
        else     bus.s0_valid = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard has been emptied by the monitor.
    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_valid"},  bus.m_valid,  0);
        check({tag, "_m_data"},   bus.m_data,   0);
        check({tag, "_m_last"},   bus.m_last,   0);
        check({tag, "_m_src"},    bus.m_src,    0);
        check({tag, "_s0_ready"}, bus.s0_ready, 0);
        check({tag, "_s1_ready"}, bus.s1_ready, 0);
        check({tag, "_busy"},     busy,         0);
`ifdef CRC8_TIMEOUT_EN
        check({tag, "_abort"},    abort,        0);
`endif
    endtask

    // Downstream ready: held high, or toggled every cycle when requested.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_ready) bus.m_ready = ~bus.m_ready;
            else              bus.m_ready = 1'b1;
        end
    end

    // Monitor: every accepted output byte must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got data 0x%0h last %0b, required no output",
                             bus.m_data, bus.m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", bus.m_data, e.data);
                    check("m_last", bus.m_last, e.last);
                    check("m_src",  bus.m_src,  e.src);
                end
            end
        end
    end

`ifdef CRC8_TIMEOUT_EN
    initial begin
        abort_cnt = 0;
        forever begin
            @(negedge clk);
            if (abort) abort_cnt++;
        end
    end
`endif

    initial begin
        rst = 1'b1;
        bus.s0_valid = 1'b0; bus.s0_data = 8'h00; bus.s0_last = 1'b0;
        bus.s1_valid = 1'b0; bus.s1_data = 8'h00; bus.s1_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single zero byte from requester 0: data then CRC 0x7B.
        push(8'h00, 1'b0, 1'b0);
        push(8'h7B, 1'b1, 1'b0);
        send_byte(1'b0, 8'h00, 1'b1);
        drain("single_r0_drain");

        // Fresh reset, then both requesters contend with two 2-byte frames each.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'hB1, 1'b1, 1'b0);
        push(8'hFF, 1'b0, 1'b1); push(8'hFF, 1'b0, 1'b1); push(8'h7B, 1'b1, 1'b1);
        push(8'hFF, 1'b0, 1'b0); push(8'hFF, 1'b0, 1'b0); push(8'h7B, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1); push(8'h00, 1'b0, 1'b1); push(8'hB1, 1'b1, 1'b1);
        fork
            begin
                send_byte(1'b0, 8'h00, 1'b0); send_byte(1'b0, 8'h00, 1'b1);
                send_byte(1'b0, 8'hFF, 1'b0); send_byte(1'b0, 8'hFF, 1'b1);
            end
            begin
                send_byte(1'b1, 8'hFF, 1'b0); send_byte(1'b1, 8'hFF, 1'b1);
                send_byte(1'b1, 8'h00, 1'b0); send_byte(1'b1, 8'h00, 1'b1);
            end
        join
        drain("contention_drain");

        // Requester 1 under a toggling m_ready: same bytes, nothing lost or repeated.
        toggle_ready = 1'b1;
        push(8'h00, 1'b0, 1'b1);
        push(8'h7B, 1'b1, 1'b1);
        send_byte(1'b1, 8'h00, 1'b1);
        drain("stall_r1_drain");
        toggle_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Requester 0 single byte 0x01 (CRC 0xE0), leaving priority with requester 1.
        push(8'h01, 1'b0, 1'b0);
        push(8'hE0, 1'b1, 1'b0);
        send_byte(1'b0, 8'h01, 1'b1);
        drain("single_01_drain");

        // Reset after two of four payload bytes: no CRC may follow.
        push(8'h10, 1'b0, 1'b0);
        push(8'h20, 1'b0, 1'b0);
        send_byte(1'b0, 8'h10, 1'b0);
        send_byte(1'b0, 8'h20, 1'b0);
        check("midframe_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midframe_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_queue", exp_q.size(), 0);

        // Both contend right after reset: requester 0 must win again.
        push(8'h01, 1'b0, 1'b0); push(8'hE0, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1); push(8'h7B, 1'b1, 1'b1);
        fork
            send_byte(1'b0, 8'h01, 1'b1);
            send_byte(1'b1, 8'h00, 1'b1);
        join
        drain("post_reset_drain");

`ifdef CRC8_TIMEOUT_EN
        // Payload without last, then silence: abort and inverted CRC 0x84.
        abort_cnt = 0;
        push(8'h00, 1'b0, 1'b0);
        push(8'h84, 1'b1, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        drain("timeout_drain");
        check("abort_pulses", abort_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_crc8_arb_ctrl
